// File: rtl/ibex_irq_ctrl_pkg.sv
// Shared types for the interrupt controller: raw IRQ vector, cause encoding,
// scheduler states and the priority-index to cause mapping.
package ibex_irq_ctrl_pkg;

  localparam int NUM_FAST = 15;
  localparam int NUM_PRIO = 19;

  typedef struct packed {
    logic                irq_software;
    logic                irq_timer;
    logic                irq_external;
    logic [NUM_FAST-1:0] irq_fast;
  } irqs_t;

  typedef enum logic [5:0] {
    EXC_CAUSE_IRQ_SOFTWARE_M = {1'b1, 5'd3},
    EXC_CAUSE_IRQ_TIMER_M    = {1'b1, 5'd7},
    EXC_CAUSE_IRQ_EXTERNAL_M = {1'b1, 5'd11},
    EXC_CAUSE_IRQ_FAST_0     = {1'b1, 5'd16},
    EXC_CAUSE_IRQ_FAST_1     = {1'b1, 5'd17},
    EXC_CAUSE_IRQ_FAST_2     = {1'b1, 5'd18},
    EXC_CAUSE_IRQ_FAST_3     = {1'b1, 5'd19},
    EXC_CAUSE_IRQ_FAST_4     = {1'b1, 5'd20},
    EXC_CAUSE_IRQ_FAST_5     = {1'b1, 5'd21},
    EXC_CAUSE_IRQ_FAST_6     = {1'b1, 5'd22},
    EXC_CAUSE_IRQ_FAST_7     = {1'b1, 5'd23},
    EXC_CAUSE_IRQ_FAST_8     = {1'b1, 5'd24},
    EXC_CAUSE_IRQ_FAST_9     = {1'b1, 5'd25},
    EXC_CAUSE_IRQ_FAST_10    = {1'b1, 5'd26},
    EXC_CAUSE_IRQ_FAST_11    = {1'b1, 5'd27},
    EXC_CAUSE_IRQ_FAST_12    = {1'b1, 5'd28},
    EXC_CAUSE_IRQ_FAST_13    = {1'b1, 5'd29},
    EXC_CAUSE_IRQ_FAST_14    = {1'b1, 5'd30},
    EXC_CAUSE_IRQ_NM         = {1'b1, 5'd31}
  } exc_cause_e;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLDOFF
  } irq_ctrl_state_e;

  // Priority index: 0 is served first.
  localparam logic [4:0] PRIO_NMI       = 5'd0;
  localparam logic [4:0] PRIO_FAST0     = 5'd1;
  localparam logic [4:0] PRIO_FAST_LAST = 5'd15;
  localparam logic [4:0] PRIO_EXTERNAL  = 5'd16;
  localparam logic [4:0] PRIO_SOFTWARE  = 5'd17;
  localparam logic [4:0] PRIO_TIMER     = 5'd18;

  function automatic exc_cause_e prio_to_cause(input logic [4:0] idx);
    exc_cause_e cause;
    if (idx == PRIO_NMI) begin
      cause = EXC_CAUSE_IRQ_NM;
    end else if (idx <= PRIO_FAST_LAST) begin
      cause = exc_cause_e'({1'b1, idx + 5'd15});
    end else if (idx == PRIO_EXTERNAL) begin
      cause = EXC_CAUSE_IRQ_EXTERNAL_M;
    end else if (idx == PRIO_SOFTWARE) begin
      cause = EXC_CAUSE_IRQ_SOFTWARE_M;
    end else begin
      cause = EXC_CAUSE_IRQ_TIMER_M;
    end
    return cause;
  endfunction

endpackage

// File: rtl/ibex_irq_prio_enc.sv
// Fixed-priority encoder: bit 0 wins; reports whether any input is set and
// the index of the winner.
module ibex_irq_prio_enc
  import ibex_irq_ctrl_pkg::*;
(
  input  logic [NUM_PRIO-1:0] req,
  output logic                valid,
  output logic [4:0]          id
);

  logic [NUM_PRIO-1:0] gnt;

  assign gnt[0] = req[0];

  for (genvar gi = 1; gi < NUM_PRIO; gi++) begin : g_gnt
    assign gnt[gi] = req[gi] & ~|req[gi-1:0];
  end

  assign valid = |req;

  // gnt is one-hot (or zero), so OR-ing the indices yields the winner.
  always_comb begin
    id = '0;
    for (int i = 0; i < NUM_PRIO; i++) begin
      if (gnt[i]) begin
        id = id | 5'(i);
      end
    end
  end

endmodule

// File: rtl/ibex_irq_ctrl.sv
// Interrupt scheduler: captures level/edge sources and the NMI, masks them,
// and presents one frozen cause to the core under a req/ack handshake.
module ibex_irq_ctrl
  import ibex_irq_ctrl_pkg::*;
#(
  parameter logic [14:0] FastIrqEdge   = 15'h0000,
  parameter int unsigned HoldoffCycles = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  irqs_t      irqs_i,
  input  logic       irq_nm_i,
  input  irqs_t      mie_i,
  input  logic       mstatus_mie_i,
  input  logic       debug_mode_i,
  input  logic       irq_ack_i,
  input  logic       nmi_ret_i,
  output logic       irq_req_o,
  output exc_cause_e irq_cause_o,
  output logic [4:0] irq_id_o,
  output irqs_t      mip_o,
  output logic       nmi_mode_o
);

  irqs_t               irqs_reg;
  logic [NUM_FAST-1:0] fast_prev_reg;
  logic [NUM_FAST-1:0] fast_pend_reg;
  logic                nmi_prev_reg;
  logic                nmi_pend_reg;
  logic                nmi_mode_reg;
  irq_ctrl_state_e     state_reg;
  exc_cause_e          cause_reg;
  logic [4:0]          id_reg;
  logic [4:0]          prio_idx_reg;
  logic [3:0]          cnt_reg;
  logic                req_reg;

  logic [NUM_FAST-1:0] fast_set;
  logic [NUM_FAST-1:0] fast_clr;
  logic [NUM_FAST-1:0] fast_pend_next;
  logic [NUM_FAST-1:0] mip_fast;
  logic                nmi_pend_next;
  logic                ack_fire;
  logic                ack_nmi;
  logic                gate;
  irqs_t               mip;
  logic [NUM_PRIO-1:0] prio_req;
  logic                enc_valid;
  logic [4:0]          enc_id;
  exc_cause_e          win_cause;

  assign ack_fire = (state_reg == REQ) && irq_ack_i;
  assign ack_nmi  = ack_fire && (prio_idx_reg == PRIO_NMI);
  assign gate     = mstatus_mie_i & ~nmi_mode_reg & ~debug_mode_i;

  // Per fast line: edge-captured bits are sticky until their own ack, and a
  // fresh edge in the ack cycle keeps the bit set.
  for (genvar gi = 0; gi < NUM_FAST; gi++) begin : g_fast
    assign fast_set[gi]       = FastIrqEdge[gi] & irqs_i.irq_fast[gi] & ~fast_prev_reg[gi];
    assign fast_clr[gi]       = ack_fire && (prio_idx_reg == PRIO_FAST0 + 5'(gi));
    assign fast_pend_next[gi] = (fast_pend_reg[gi] & ~fast_clr[gi]) | fast_set[gi];
    assign mip_fast[gi]       = FastIrqEdge[gi] ? fast_pend_reg[gi] : irqs_reg.irq_fast[gi];
    assign prio_req[gi + 1]   = mip_fast[gi] & mie_i.irq_fast[gi] & gate;
  end

  assign nmi_pend_next = (nmi_pend_reg & ~ack_nmi) | (irq_nm_i & ~nmi_prev_reg);

  always_comb begin
    mip          = irqs_reg;
    mip.irq_fast = mip_fast;
  end

  assign prio_req[PRIO_NMI]      = nmi_pend_reg & ~nmi_mode_reg & ~debug_mode_i;
  assign prio_req[PRIO_EXTERNAL] = mip.irq_external & mie_i.irq_external & gate;
  assign prio_req[PRIO_SOFTWARE] = mip.irq_software & mie_i.irq_software & gate;
  assign prio_req[PRIO_TIMER]    = mip.irq_timer & mie_i.irq_timer & gate;

  ibex_irq_prio_enc u_prio_enc (
    .req   (prio_req),
    .valid (enc_valid),
    .id    (enc_id)
  );

  assign win_cause = prio_to_cause(enc_id);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      irqs_reg      <= '0;
      fast_prev_reg <= '0;
      fast_pend_reg <= '0;
      nmi_prev_reg  <= 1'b0;
      nmi_pend_reg  <= 1'b0;
      nmi_mode_reg  <= 1'b0;
      state_reg     <= IDLE;
      cause_reg     <= EXC_CAUSE_IRQ_SOFTWARE_M;
      id_reg        <= '0;
      prio_idx_reg  <= '0;
      cnt_reg       <= '0;
      req_reg       <= 1'b0;
    end else begin
      irqs_reg      <= irqs_i;
      fast_prev_reg <= irqs_i.irq_fast;
      fast_pend_reg <= fast_pend_next;
      nmi_prev_reg  <= irq_nm_i;
      nmi_pend_reg  <= nmi_pend_next;

      // Entering the NMI handler outranks a simultaneous return.
      if (ack_nmi) begin
        nmi_mode_reg <= 1'b1;
      end else if (nmi_ret_i) begin
        nmi_mode_reg <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (enc_valid) begin
            state_reg    <= REQ;
            req_reg      <= 1'b1;
            prio_idx_reg <= enc_id;
            cause_reg    <= win_cause;
            id_reg       <= win_cause[4:0];
          end
        end
        REQ: begin
          if (irq_ack_i) begin
            req_reg <= 1'b0;
            if (HoldoffCycles == 0) begin
              state_reg <= IDLE;
            end else begin
              state_reg <= HOLDOFF;
              cnt_reg   <= 4'(HoldoffCycles);
            end
          end else if (!prio_req[prio_idx_reg]) begin
            state_reg <= IDLE;
            req_reg   <= 1'b0;
          end
        end
        HOLDOFF: begin
          if (cnt_reg <= 4'd1) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        default: begin
          state_reg <= IDLE;
          req_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign irq_req_o   = req_reg;
  assign irq_cause_o = cause_reg;
  assign irq_id_o    = id_reg;
  assign mip_o       = mip;
  assign nmi_mode_o  = nmi_mode_reg;

endmodule

// File: tb/tb_ibex_irq_ctrl.sv
// Bench for ibex_irq_ctrl: a vector table for the level-source flows, then
// hand-written sequences for edge capture, NMI nesting, withdraw, debug, reset.
module tb_ibex_irq_ctrl;
  import ibex_irq_ctrl_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  irqs_t      irqs_i;
  logic       irq_nm_i;
  irqs_t      mie_i;
  logic       mstatus_mie_i;
  logic       debug_mode_i;
  logic       irq_ack_i;
  logic       nmi_ret_i;
  logic       irq_req_o;
  exc_cause_e irq_cause_o;
  logic [4:0] irq_id_o;
  irqs_t      mip_o;
  logic       nmi_mode_o;

  always #5 clk_i = ~clk_i;

  ibex_irq_ctrl #(
    .FastIrqEdge   (15'h0020),
    .HoldoffCycles (2)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .irqs_i        (irqs_i),
    .irq_nm_i      (irq_nm_i),
    .mie_i         (mie_i),
    .mstatus_mie_i (mstatus_mie_i),
    .debug_mode_i  (debug_mode_i),
    .irq_ack_i     (irq_ack_i),
    .nmi_ret_i     (nmi_ret_i),
    .irq_req_o     (irq_req_o),
    .irq_cause_o   (irq_cause_o),
    .irq_id_o      (irq_id_o),
    .mip_o         (mip_o),
    .nmi_mode_o    (nmi_mode_o)
  );

  localparam logic [17:0] TMR = 18'h10000;
  localparam logic [17:0] EXT = 18'h08000;
  localparam logic [17:0] F3  = 18'h00008;
  localparam logic [17:0] F5  = 18'h00020;
  localparam logic [17:0] ALL = 18'h3FFFF;
  localparam logic [17:0] NO  = 18'h00000;

  localparam logic [5:0] C_TMR = 6'h27;
  localparam logic [5:0] C_EXT = 6'h2B;
  localparam logic [5:0] C_F3  = 6'h33;
  localparam logic [5:0] C_F5  = 6'h35;
  localparam logic [5:0] C_NMI = 6'h3F;
  localparam logic [5:0] C_RST = 6'h23;
  localparam logic [5:0] C_X   = 6'h00;

  typedef struct {
    string       name;
    logic        req;
    logic [5:0]  cause;
    logic [4:0]  id;
    logic        cc;
    logic [17:0] mip;
    logic        cm;
    logic        nmi;
  } exp_t;

  typedef struct {
    logic        rst;
    logic [17:0] irqs;
    logic [17:0] mie;
    logic        mst;
    logic        ack;
    logic        e_req;
    logic [5:0]  e_cause;
    logic        e_cc;
  } vec_t;

  exp_t exp_q[$];
  vec_t vt[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(logic rst, logic [17:0] irqs, logic [17:0] mie, logic mst,
                              logic ack, logic e_req, logic [5:0] e_cause, logic e_cc);
    vec_t v;
    v.rst = rst; v.irqs = irqs; v.mie = mie; v.mst = mst; v.ack = ack;
    v.e_req = e_req; v.e_cause = e_cause; v.e_cc = e_cc;
    return v;
  endfunction

  task automatic drv(logic [17:0] irqs, logic [17:0] mie, logic mst, logic ack,
                     logic nm, logic ret, logic dbg);
    irqs_i        = irqs;
    mie_i         = mie;
    mstatus_mie_i = mst;
    irq_ack_i     = ack;
    irq_nm_i      = nm;
    nmi_ret_i     = ret;
    debug_mode_i  = dbg;
  endtask

  task automatic push_exp(string nm, logic r, logic [5:0] c, logic [4:0] id, logic cc,
                          logic [17:0] m, logic cm, logic nmi);
    exp_t e;
    e.name = nm; e.req = r; e.cause = c; e.id = id; e.cc = cc;
    e.mip = m; e.cm = cm; e.nmi = nmi;
    exp_q.push_back(e);
  endtask

  // Advance to the next falling edge and score the oldest pending expectation.
  task automatic cycle_check();
    exp_t e;
    @(negedge clk_i);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      total++;
      if (irq_req_o !== e.req || nmi_mode_o !== e.nmi ||
          (e.cc && (6'(irq_cause_o) !== e.cause || irq_id_o !== e.id)) ||
          (e.cm && 18'(mip_o) !== e.mip)) begin
        bad++;
        $display("FAIL %s: got req=%0b cause=%h id=%0d mip=%h nmi=%0b, want req=%0b cause=%h id=%0d mip=%h nmi=%0b",
                 e.name, irq_req_o, 6'(irq_cause_o), irq_id_o, 18'(mip_o), nmi_mode_o,
                 e.req, e.cause, e.id, e.mip, e.nmi);
      end else begin
        $display("ok   %s: req=%0b cause=%h id=%0d mip=%h nmi=%0b",
                 e.name, irq_req_o, 6'(irq_cause_o), irq_id_o, 18'(mip_o), nmi_mode_o);
      end
    end
  endtask

  task automatic step(string nm, logic r, logic [5:0] c, logic [17:0] m, logic nmi);
    push_exp(nm, r, c, c[4:0], r, m, 1'b1, nmi);
    cycle_check();
  endtask

  task automatic do_reset(string nm);
    rst_ni = 1'b0;
    push_exp(nm, 1'b0, C_RST, 5'd0, 1'b1, NO, 1'b1, 1'b0);
    cycle_check();
    rst_ni = 1'b1;
    drv(NO, NO, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0;
    drv(NO, NO, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    @(negedge clk_i);

    // Timer request, ack, hold-off, re-request while the level stays high.
    vt.push_back(mk(1, NO,  NO,  0, 0, 0, C_RST, 1));
    vt.push_back(mk(0, TMR, TMR, 1, 0, 0, C_X,   0));
    vt.push_back(mk(0, TMR, TMR, 1, 0, 1, C_TMR, 1));
    vt.push_back(mk(0, TMR, TMR, 1, 1, 0, C_X,   0));
    vt.push_back(mk(0, TMR, TMR, 1, 0, 0, C_X,   0));
    vt.push_back(mk(0, TMR, TMR, 1, 0, 0, C_X,   0));
    vt.push_back(mk(0, TMR, TMR, 1, 0, 1, C_TMR, 1));
    vt.push_back(mk(0, NO,  TMR, 1, 1, 0, C_X,   0));
    // Frozen cause, then fast[3] beats external after hold-off.
    vt.push_back(mk(1, NO,              NO,  0, 0, 0, C_RST, 1));
    vt.push_back(mk(0, TMR,             ALL, 1, 0, 0, C_X,   0));
    vt.push_back(mk(0, TMR,             ALL, 1, 0, 1, C_TMR, 1));
    vt.push_back(mk(0, TMR | F3 | EXT,  ALL, 1, 0, 1, C_TMR, 1));
    vt.push_back(mk(0, TMR | F3 | EXT,  ALL, 1, 0, 1, C_TMR, 1));
    vt.push_back(mk(0, F3 | EXT,        ALL, 1, 1, 0, C_X,   0));
    vt.push_back(mk(0, F3 | EXT,        ALL, 1, 0, 0, C_X,   0));
    vt.push_back(mk(0, F3 | EXT,        ALL, 1, 0, 0, C_X,   0));
    vt.push_back(mk(0, F3 | EXT,        ALL, 1, 0, 1, C_F3,  1));
    vt.push_back(mk(0, EXT,             ALL, 1, 1, 0, C_X,   0));
    vt.push_back(mk(0, EXT,             ALL, 1, 0, 0, C_X,   0));
    vt.push_back(mk(0, EXT,             ALL, 1, 0, 0, C_X,   0));
    vt.push_back(mk(0, EXT,             ALL, 1, 0, 1, C_EXT, 1));
    vt.push_back(mk(0, NO,              ALL, 1, 1, 0, C_X,   0));
    vt.push_back(mk(0, NO,              ALL, 1, 0, 0, C_X,   0));
    vt.push_back(mk(0, NO,              ALL, 1, 0, 0, C_X,   0));
    vt.push_back(mk(0, NO,              ALL, 1, 0, 0, C_X,   0));

    foreach (vt[k]) begin
      rst_ni = ~vt[k].rst;
      drv(vt[k].irqs, vt[k].mie, vt[k].mst, vt[k].ack, 0, 0, 0);
      push_exp($sformatf("tbl[%0d]", k), vt[k].e_req, vt[k].e_cause,
               vt[k].rst ? 5'd0 : vt[k].e_cause[4:0], vt[k].e_cc,
               vt[k].rst ? NO : vt[k].irqs, 1'b1, 1'b0);
      cycle_check();
    end
    rst_ni = 1'b1;

    // Edge-captured fast[5]: sticky pending, ack clears, coincident edge wins.
    do_reset("f5_reset");
    drv(F5, F5, 0, 0, 0, 0, 0); step("f5_pulse",        0, C_X,  F5, 0);
    drv(NO, F5, 0, 0, 0, 0, 0); step("f5_sticky_a",     0, C_X,  F5, 0);
    drv(NO, F5, 0, 0, 0, 0, 0); step("f5_sticky_b",     0, C_X,  F5, 0);
    drv(NO, F5, 1, 0, 0, 0, 0); step("f5_req",          1, C_F5, F5, 0);
    drv(NO, F5, 1, 1, 0, 0, 0); step("f5_ack_clr",      0, C_X,  NO, 0);
    drv(F5, F5, 1, 0, 0, 0, 0); step("f5_repulse",      0, C_X,  F5, 0);
    drv(NO, F5, 1, 1, 0, 0, 0); step("f5_ack_ignored",  0, C_X,  F5, 0);
    drv(NO, F5, 1, 0, 0, 0, 0); step("f5_req2",         1, C_F5, F5, 0);
    drv(F5, F5, 1, 1, 0, 0, 0); step("f5_ack_set_wins", 0, C_X,  F5, 0);
    drv(NO, F5, 1, 0, 0, 0, 0); step("f5_still_set",    0, C_X,  F5, 0);

    // NMI: ignores mstatus.MIE, nests, second edge waits for nmi_ret.
    do_reset("nmi_reset");
    drv(NO,  TMR, 0, 0, 1, 0, 0); step("nmi_pend",      0, C_X,   NO,  0);
    drv(NO,  TMR, 0, 0, 1, 0, 0); step("nmi_req",       1, C_NMI, NO,  0);
    drv(NO,  TMR, 0, 1, 0, 0, 0); step("nmi_ack",       0, C_X,   NO,  1);
    drv(TMR, TMR, 1, 0, 1, 0, 0); step("nmi_2nd_edge",  0, C_X,   TMR, 1);
    for (int i = 0; i < 3; i++) begin
      drv(TMR, TMR, 1, 0, 0, 0, 0); step($sformatf("nmi_masked_%0d", i), 0, C_X, TMR, 1);
    end
    drv(TMR, TMR, 1, 0, 0, 1, 0); step("nmi_ret",       0, C_X,   TMR, 0);
    drv(TMR, TMR, 1, 0, 0, 0, 0); step("nmi_again",     1, C_NMI, TMR, 0);
    drv(TMR, TMR, 1, 1, 0, 1, 0); step("nmi_ack_ret",   0, C_X,   TMR, 1);
    drv(TMR, TMR, 1, 0, 0, 0, 0); step("nmi_mode_held", 0, C_X,   TMR, 1);

    // Withdraw without ack, then ack coinciding with the drop.
    do_reset("wd_reset");
    drv(EXT, EXT, 1, 0, 0, 0, 0); step("wd_raise",    0, C_X,   EXT, 0);
    drv(EXT, EXT, 1, 0, 0, 0, 0); step("wd_req",      1, C_EXT, EXT, 0);
    drv(NO,  EXT, 1, 0, 0, 0, 0); step("wd_drop_reg", 1, C_EXT, NO,  0);
    drv(NO,  EXT, 1, 0, 0, 0, 0); step("wd_withdraw", 0, C_X,   NO,  0);
    drv(EXT, EXT, 1, 0, 0, 0, 0); step("wd_reraise",  0, C_X,   EXT, 0);
    drv(EXT, EXT, 1, 0, 0, 0, 0); step("wd_req2",     1, C_EXT, EXT, 0);
    drv(NO,  EXT, 1, 0, 0, 0, 0); step("wd_drop2",    1, C_EXT, NO,  0);
    drv(NO,  EXT, 1, 1, 0, 0, 0); step("wd_ack_wins", 0, C_X,   NO,  0);
    drv(EXT, EXT, 1, 0, 0, 0, 0); step("wd_holdoff1", 0, C_X,   EXT, 0);
    drv(EXT, EXT, 1, 0, 0, 0, 0); step("wd_holdoff2", 0, C_X,   EXT, 0);
    drv(EXT, EXT, 1, 0, 0, 0, 0); step("wd_req3",     1, C_EXT, EXT, 0);

    // Debug mode blocks everything; reset in REQ drops the request.
    do_reset("dbg_reset");
    drv(TMR, TMR, 1, 0, 1, 0, 1); step("dbg_pend", 0, C_X, TMR, 0);
    for (int i = 0; i < 3; i++) begin
      drv(TMR, TMR, 1, 0, 0, 0, 1); step($sformatf("dbg_block_%0d", i), 0, C_X, TMR, 0);
    end
    drv(TMR, TMR, 1, 0, 0, 0, 0); step("dbg_exit", 1, C_NMI, TMR, 0);
    do_reset("rst_in_req");
    drv(NO, NO, 0, 0, 0, 0, 0); step("post_rst", 0, C_X, NO, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
